// File: rtl/taitosj_pkg.sv
// Shared definitions for the Taito SJ ROM loader: ROM region map, region codes
// and loader FSM states.
package taitosj_pkg;

  localparam logic [24:0] MAIN_BASE = 25'h00000;
  localparam logic [24:0] SND_BASE  = 25'h0A000;
  localparam logic [24:0] GFX_BASE  = 25'h0C000;
  localparam logic [24:0] MCU_BASE  = 25'h14000;
  localparam logic [24:0] PROM_BASE = 25'h14800;
  localparam logic [24:0] MAP_END   = 25'h14900;

  typedef enum logic [2:0] {
    RGN_NONE,
    RGN_MAIN,
    RGN_SND,
    RGN_GFX,
    RGN_MCU,
    RGN_PROM
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_RUN
  } state_e;

endpackage

// File: rtl/taitosj_region_decode.sv
// Combinational decode of an absolute download address into a ROM region code
// and the byte offset within that region.
module taitosj_region_decode
  import taitosj_pkg::*;
(
  input  logic [24:0] addr,
  output logic [2:0]  region,
  output logic [14:0] offset
);

  logic [14:0] base_lo;

  // The offset is only 15 bits wide, so the upper 8 KB of main ROM aliases onto its lower part.
  always_comb begin
    region  = RGN_NONE;
    base_lo = 15'd0;
    if (addr < SND_BASE) begin
      region  = RGN_MAIN;
      base_lo = MAIN_BASE[14:0];
    end else if (addr < GFX_BASE) begin
      region  = RGN_SND;
      base_lo = SND_BASE[14:0];
    end else if (addr < MCU_BASE) begin
      region  = RGN_GFX;
      base_lo = GFX_BASE[14:0];
    end else if (addr < PROM_BASE) begin
      region  = RGN_MCU;
      base_lo = MCU_BASE[14:0];
    end else if (addr < MAP_END) begin
      region  = RGN_PROM;
      base_lo = PROM_BASE[14:0];
    end
    offset = addr[14:0] - base_lo;
  end

endmodule

// File: rtl/taitosj_rom_loader.sv
// Routes HPS ioctl download bytes into the Taito SJ ROM regions, captures DIP and
// mod bytes, and holds the game core in reset until a complete image has loaded.
module taitosj_rom_loader
  import taitosj_pkg::*;
#(
  parameter logic [16:0] EXPECTED_BYTES = 17'h14900,
  parameter logic [7:0]  DIP_INDEX      = 8'd254,
  parameter logic [7:0]  MOD_INDEX      = 8'd1
) (
  input  logic        clkm_32MHZ,
  input  logic        RESET_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        main_we,
  output logic        snd_we,
  output logic        gfx_we,
  output logic        mcu_we,
  output logic        prom_we,
  output logic [14:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [7:0]  dip0,
  output logic [7:0]  dip1,
  output logic [7:0]  dip2,
  output logic [7:0]  dip3,
  output logic [7:0]  dip4,
  output logic [7:0]  dip5,
  output logic [7:0]  dip6,
  output logic [7:0]  dip7,
  output logic [7:0]  pcb,
  output logic        core_hold,
  output logic        load_error,
  output logic [16:0] bytes_loaded
);

  state_e      state_q, state_d;
  logic        dl_q;
  logic [4:0]  we_q, we_d;
  logic [14:0] rom_addr_q, rom_addr_d;
  logic [7:0]  rom_data_q, rom_data_d;
  logic [16:0] bytes_q, bytes_d;
  logic        err_pend_q, err_pend_d;
  logic        load_error_q, load_error_d;
  logic [7:0]  dip_q [8];
  logic [7:0]  dip_d [8];
  logic [7:0]  pcb_q, pcb_d;

  logic [2:0]  region;
  logic [14:0] offset;
  logic        dl_rise, dl_fall, accept;

  taitosj_region_decode u_decode (
    .addr   (ioctl_addr),
    .region (region),
    .offset (offset)
  );

  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;
  // dl_q keeps the strobe that lands on the falling edge of ioctl_download valid.
  assign accept  = (state_q == ST_LOAD) && (ioctl_index == 8'd0) && ioctl_wr &&
                   (ioctl_download || dl_q);

  always_comb begin
    state_d      = state_q;
    we_d         = 5'b00000;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;
    bytes_d      = bytes_q;
    err_pend_d   = err_pend_q;
    load_error_d = load_error_q;
    dip_d        = dip_q;
    pcb_d        = pcb_q;

    case (state_q)
      ST_LOAD:  if (dl_fall) state_d = ST_CHECK;
      ST_CHECK: begin
        load_error_d = err_pend_q | (bytes_q < EXPECTED_BYTES);
        state_d      = ST_RUN;
      end
      default: ;
    endcase

    if (accept) begin
      bytes_d = (bytes_q == 17'h1FFFF) ? bytes_q : bytes_q + 17'd1;
      case (region)
        RGN_MAIN: we_d = 5'b00001;
        RGN_SND:  we_d = 5'b00010;
        RGN_GFX:  we_d = 5'b00100;
        RGN_MCU:  we_d = 5'b01000;
        RGN_PROM: we_d = 5'b10000;
        default:  err_pend_d = 1'b1;
      endcase
      if (region != RGN_NONE) begin
        rom_addr_d = offset;
        rom_data_d = ioctl_dout;
      end
    end

    // A new index-0 download restarts the image from any state, including a glitch mid-load.
    if (dl_rise && (ioctl_index == 8'd0)) begin
      state_d    = ST_LOAD;
      bytes_d    = 17'd0;
      err_pend_d = 1'b0;
    end

    if (ioctl_wr && (ioctl_index == DIP_INDEX) && (ioctl_addr[24:3] == 22'd0))
      dip_d[ioctl_addr[2:0]] = ioctl_dout;
    if (ioctl_wr && (ioctl_index == MOD_INDEX) && (ioctl_addr == 25'd0))
      pcb_d = ioctl_dout;
  end

  always_ff @(posedge clkm_32MHZ) begin
    dl_q <= ioctl_download;
    if (!RESET_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 5'b00000;
      rom_addr_q   <= 15'd0;
      rom_data_q   <= 8'd0;
      bytes_q      <= 17'd0;
      err_pend_q   <= 1'b0;
      load_error_q <= 1'b0;
      pcb_q        <= 8'd0;
      for (int i = 0; i < 8; i++) dip_q[i] <= 8'hFF;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      bytes_q      <= bytes_d;
      err_pend_q   <= err_pend_d;
      load_error_q <= load_error_d;
      pcb_q        <= pcb_d;
      for (int i = 0; i < 8; i++) dip_q[i] <= dip_d[i];
    end
  end

  assign main_we      = we_q[0];
  assign snd_we       = we_q[1];
  assign gfx_we       = we_q[2];
  assign mcu_we       = we_q[3];
  assign prom_we      = we_q[4];
  assign rom_addr     = rom_addr_q;
  assign rom_data     = rom_data_q;
  assign bytes_loaded = bytes_q;
  assign load_error   = load_error_q;
  assign pcb          = pcb_q;
  assign core_hold    = (state_q != ST_RUN) || load_error_q;
  assign dip0 = dip_q[0];
  assign dip1 = dip_q[1];
  assign dip2 = dip_q[2];
  assign dip3 = dip_q[3];
  assign dip4 = dip_q[4];
  assign dip5 = dip_q[5];
  assign dip6 = dip_q[6];
  assign dip7 = dip_q[7];

endmodule
